nibble_alu: RTL

Arithmetic/logic stage of the Nibbler CPU, directly upstream of the accumulator register. Combines the current accumulator value with an operand nibble from the data bus or ROM immediate field. Registers the result plus carry and zero flags, and raises a one-cycle `done` strobe that the controller uses to load the result into the accumulator. Most operations complete in one cycle; an optional iterative multiply takes WIDTH cycles and holds `busy` while running.

---
 rtl/nibble_alu_if.sv | 24 ++
 rtl/nibble_alu.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/nibble_alu_if.sv
// Request/response bundle between the Nibbler controller and the nibble ALU.
interface nibble_alu_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] accIn;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             done;
    logic             busy;

    modport master (
        output start, op, accIn, operand,
        input  result, carry, zero, done, busy
    );

    modport slave (
        input  start, op, accIn, operand,
        output result, carry, zero, done, busy
    );
endinterface

// File: rtl/nibble_alu.sv
// Nibbler ALU stage: registered result, carry/zero flags and a one-cycle done strobe.
// Define ALU_MUL_EN to build the iterative WIDTH-cycle shift-add multiply for op 110.
module nibble_alu #(
    parameter int unsigned WIDTH = 4
) (
    input logic         clk,
    input logic         reset,
    nibble_alu_if.slave bus
);
    localparam logic [2:0] OpPass = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpAdc  = 3'b010;
    localparam logic [2:0] OpSub  = 3'b011;
    localparam logic [2:0] OpNand = 3'b100;
    localparam logic [2:0] OpCmp  = 3'b101;
    localparam logic [2:0] OpMul  = 3'b110;
    localparam logic [2:0] OpNop  = 3'b111;

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             idle;
    logic             accept;
    logic [WIDTH:0]   add_sum, adc_sum, sub_sum;

    assign accept  = idle & bus.start;
    assign add_sum = {1'b0, bus.accIn} + {1'b0, bus.operand};
    assign adc_sum = add_sum + {{WIDTH{1'b0}}, carry_q};
    // Two's-complement subtract; bit WIDTH set means no borrow.
    assign sub_sum = {1'b0, bus.accIn} + {1'b0, ~bus.operand} + {{WIDTH{1'b0}}, 1'b1};

`ifdef ALU_MUL_EN
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {StIdle, StMul} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_step;

    assign idle      = (state_q == StIdle);
    assign bus.busy  = (state_q == StMul);
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
`else
    assign idle     = 1'b1;
    assign bus.busy = 1'b0;
`endif

    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
`ifdef ALU_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        if (accept) begin
            done_d = 1'b1;
            unique case (bus.op)
                OpPass: begin
                    result_d = bus.operand;
                    zero_d   = (bus.operand == '0);
                end
                OpAdd: begin
                    {carry_d, result_d} = add_sum;
                    zero_d = (add_sum[WIDTH-1:0] == '0);
                end
                OpAdc: begin
                    {carry_d, result_d} = adc_sum;
                    zero_d = (adc_sum[WIDTH-1:0] == '0);
                end
                OpSub: begin
                    {carry_d, result_d} = sub_sum;
                    zero_d = (sub_sum[WIDTH-1:0] == '0);
                end
                OpNand: begin
                    result_d = ~(bus.accIn & bus.operand);
                    zero_d   = ((bus.accIn & bus.operand) == {WIDTH{1'b1}});
                end
                OpCmp: begin
                    carry_d = sub_sum[WIDTH];
                    zero_d  = (sub_sum[WIDTH-1:0] == '0);
                end
                OpMul: begin
`ifdef ALU_MUL_EN
                    done_d   = 1'b0;
                    state_d  = StMul;
                    cnt_d    = '0;
                    prod_d   = '0;
                    mcand_d  = {{WIDTH{1'b0}}, bus.accIn};
                    mplier_d = bus.operand;
`endif
                end
                OpNop: ;
                default: ;
            endcase
        end
`ifdef ALU_MUL_EN
        if (state_q == StMul) begin
            prod_d   = prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
                state_d  = StIdle;
                done_d   = 1'b1;
                result_d = prod_step[WIDTH-1:0];
                carry_d  = |prod_step[2*WIDTH-1:WIDTH];
                zero_d   = (prod_step[WIDTH-1:0] == '0);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
    assign bus.done   = done_q;
endmodule
